pc_fetch_stage: RTL and testbench
=================================

// Module: pc_fetch_stage
// PURPOSE
//  Program-counter register plus instruction-fetch sequencer. Holds the PC, issues one
//  instruction-memory request per instruction, latches the returned word into the IR and
//  presents it to decode with a valid/ready handshake. Sits directly upstream of the 2:1
//  16-bit next-PC mux: pc_plus2 feeds mux input a, and the branch/jump target feeds input b.
//  The selected value returns on redirect_pc whenever redirect is asserted.
// PARAMETERS
//  WIDTH     16       datapath / address width
//  RESET_PC  16'h0000 PC value loaded on reset
//  PC_STEP   2        PC increment per instruction (byte-addressed 16-bit words)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  stall        in   1      hazard stall from control; blocks handoff to decode
//  redirect     in   1      taken branch/jump this cycle
//  redirect_pc  in   WIDTH  next-PC from the 2:1 next-PC mux; bit 0 ignored (forced 0)
//  halt         in   1      stop fetching after the current instruction is handed off
//  imem_req     out  1      one-cycle request pulse to instruction memory
//  imem_addr    out  WIDTH  request address; equals pc while imem_req=1
//  imem_valid   in   1      response strobe; arrives >=1 cycle after imem_req
//  imem_rdata   in   WIDTH  instruction word, valid with imem_valid
//  ir_out       out  WIDTH  latched instruction
//  pc_out       out  WIDTH  PC of the instruction in ir_out
//  pc_plus2     out  WIDTH  pc_out + PC_STEP, mod 2^WIDTH
//  ir_valid     out  1      ir_out/pc_out valid for decode
//  ir_ready     in   1      decode accepts the instruction this cycle
//  halted       out  1      fetch stopped
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC; state=BOOT; imem_req=0; imem_addr=RESET_PC;
//    ir_out=0; pc_out=0; ir_valid=0; halted=0; squash=0. Outputs are registered.
//  Handoff: a handoff occurs when ir_valid & ir_ready & !stall.
//  States:
//   BOOT  : one idle cycle after reset release -> REQ.
//   REQ   : imem_req=1, imem_addr=pc, for exactly 1 cycle -> WAIT.
//   WAIT  : on imem_valid & !squash: ir_out<=imem_rdata; pc_out<=pc; ir_valid<=1;
//           pc<=pc+PC_STEP -> HOLD. On imem_valid & squash: discard word; squash<=0 -> REQ.
//   HOLD  : ir_valid held with stable ir_out/pc_out until a handoff. On handoff:
//           ir_valid<=0 -> HALTED if halt, else REQ.
//   HALTED: halted=1, no requests; exits only through reset.
//  Redirect: redirect has priority over everything except reset; pc<={redirect_pc[15:1],1'b0}.
//   - WAIT before the response, or in the same cycle as imem_valid: the response is
//     squashed (squash<=1 if still pending); the stage issues no new request until the
//     stale response returns.
//   - HOLD: ir_valid<=0 next cycle, regardless of ready -> REQ.
//   - BOOT/REQ: pc updated; the in-flight REQ is squashed as in WAIT.
//   - HALTED: ignored.
//  Simultaneous redirect+halt: pc is redirected, then the stage enters HALTED (no fetch).
//  Wrap-around: pc 16'hFFFE + 2 -> 16'h0000; pc_plus2 wraps identically; no flag.
//  Latency: reset release -> first imem_req is 2 cycles. Zero-wait memory gives one
//   instruction per 3 cycles (REQ, WAIT, HOLD with ready=1).
//  Stall holds HOLD indefinitely; the stage never drops ir_valid except on handoff or redirect.
//  Mid-operation reset: all state returns to reset values immediately; a later imem_valid
//   is ignored because the state is BOOT or REQ.
// STRUCTURE
//  Shared header processor_defs.vh: WIDTH, RESET_PC, PC_STEP, state encodings
//   (BOOT, REQ, WAIT, HOLD, HALTED; 3-bit).
//  One sub-module: pc_reg (WIDTH-bit register, async active-low reset to RESET_PC,
//   load enable). The FSM, squash flag and IR latch stay in this module.
// TESTING
//  1 Reset then free-run, ir_ready=1, memory returns pc^16'hA5A5 one cycle later
//    -> imem_addr 0,2,4,...; ir_out=addr^A5A5; pc_plus2=pc_out+2.
//  2 Hold stall=1 for 5 cycles in HOLD -> ir_valid, ir_out, pc_out stable; no imem_req.
//    Release stall -> one handoff, then next imem_req at pc_out+2.
//  3 redirect=1, redirect_pc=16'h0041 while in WAIT -> stale word discarded, never
//    ir_valid; next imem_addr=16'h0040.
//  4 Load pc=16'hFFFE through a redirect -> fetch FFFE, then imem_addr=0000; pc_plus2=0000.
//  5 halt=1 during HOLD, ready=1 -> handoff, halted=1, no further imem_req for 20 cycles;
//    redirect in HALTED is ignored.
//  6 rst_n=0 asynchronously mid-WAIT -> outputs at reset values before the next edge;
//    late imem_valid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_stage_pkg.sv
// Shared constants for the fetch stage: datapath width, reset PC, PC step and
// the 3-bit FSM state encodings.
package pc_fetch_stage_pkg;

   localparam int          FETCH_WIDTH    = 16;
   localparam logic [15:0] FETCH_RESET_PC = 16'h0000;
   localparam int          FETCH_PC_STEP  = 2;

   typedef logic [2:0] fetch_state_t;

   localparam fetch_state_t S_BOOT   = 3'd0;
   localparam fetch_state_t S_REQ    = 3'd1;
   localparam fetch_state_t S_WAIT   = 3'd2;
   localparam fetch_state_t S_HOLD   = 3'd3;
   localparam fetch_state_t S_HALTED = 3'd4;

endpackage

// File: rtl/pc_fetch_stage_pc_reg.sv
// Program-counter register: asynchronous active-low reset to RESET_PC,
// loads d when load is high.
module pc_reg #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_PC;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch sequencer: holds the PC, issues one instruction-memory request per
// instruction, latches the returned word into the IR and hands it to decode.
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter int               WIDTH    = FETCH_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC),
   parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(FETCH_PC_STEP)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             halt,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_valid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] ir_out,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus2,
   output logic             ir_valid,
   input  logic             ir_ready,
   output logic             halted,
   output fetch_state_t     dbg_state
);

   // Handshake: decode takes the instruction on a cycle where ir_valid and
   // ir_ready are both high and stall is low. Once raised, ir_valid holds with
   // stable ir_out/pc_out until that handoff or a redirect drops it.

   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(1);

   fetch_state_t     state;
   fetch_state_t     state_n;
   logic             squash;
   logic             squash_n;
   logic             pc_load;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] ir_n;
   logic [WIDTH-1:0] pc_out_n;
   logic             ir_valid_n;
   logic             handoff;
   logic [WIDTH-1:0] target;

   pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pc_load),
      .d     (pc_d),
      .q     (pc)
   );

   assign handoff = ir_valid & ir_ready & ~stall;
   assign target  = redirect_pc & ALIGN_MASK;

   always_comb begin
      state_n    = state;
      squash_n   = squash;
      pc_load    = 1'b0;
      pc_d       = pc;
      ir_n       = ir_out;
      pc_out_n   = pc_out;
      ir_valid_n = ir_valid;

      case (state)
         S_BOOT: state_n = S_REQ;
         S_REQ:  state_n = S_WAIT;
         S_WAIT: begin
            if (imem_valid) begin
               if (squash) begin
                  squash_n = 1'b0;
                  state_n  = S_REQ;
               end else begin
                  ir_n       = imem_rdata;
                  pc_out_n   = pc;
                  ir_valid_n = 1'b1;
                  pc_load    = 1'b1;
                  pc_d       = pc + PC_STEP;
                  state_n    = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (handoff) begin
               ir_valid_n = 1'b0;
               state_n    = halt ? S_HALTED : S_REQ;
            end
         end
         S_HALTED: state_n = S_HALTED;
         default:  state_n = S_BOOT;
      endcase

      // A redirect overrides the normal step; any request already issued
      // (REQ) or still outstanding (WAIT without a response) must be drained
      // before the next request, so squash marks its response as stale.
      if (redirect && state != S_HALTED) begin
         pc_load    = 1'b1;
         pc_d       = target;
         ir_n       = ir_out;
         pc_out_n   = pc_out;
         ir_valid_n = 1'b0;
         case (state)
            S_REQ: begin
               squash_n = 1'b1;
               state_n  = S_WAIT;
            end
            S_WAIT: begin
               squash_n = ~imem_valid;
               state_n  = imem_valid ? S_REQ : S_WAIT;
            end
            default: state_n = S_REQ;
         endcase
         if (halt) begin
            squash_n = 1'b0;
            state_n  = S_HALTED;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_BOOT;
         squash   <= 1'b0;
         ir_out   <= '0;
         pc_out   <= '0;
         ir_valid <= 1'b0;
         imem_req <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_n;
         squash   <= squash_n;
         ir_out   <= ir_n;
         pc_out   <= pc_out_n;
         ir_valid <= ir_valid_n;
         imem_req <= (state_n == S_REQ);
         halted   <= (state_n == S_HALTED);
      end
   end

   assign imem_addr = pc;
   assign pc_plus2  = pc_out + PC_STEP;
   assign dbg_state = state;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage with a delayed-response memory model and
// a scoreboard of expected request addresses and decode handoffs.
module tb_pc_fetch_stage;

   localparam logic [2:0] ST_BOOT   = 3'd0;
   localparam logic [2:0] ST_REQ    = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_HALTED = 3'd4;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_valid;
   logic [15:0] imem_rdata;
   logic [15:0] ir_out;
   logic [15:0] pc_out;
   logic [15:0] pc_plus2;
   logic        ir_valid;
   logic        ir_ready;
   logic        halted;
   logic [2:0]  dbg_state;

   typedef struct {
      int          due;
      logic [15:0] data;
   } mem_ent_t;

   mem_ent_t    mem_q[$];
   int          mem_delay;
   logic [15:0] mem_xor;
   int          cyc;

   logic [15:0] exp_addr_q[$];
   logic [15:0] exp_pc_q[$];
   logic [15:0] exp_ir_q[$];
   logic [15:0] exp_p2_q[$];

   int n_checks;
   int n_fail;

   pc_fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_rdata  (imem_rdata),
      .ir_out      (ir_out),
      .pc_out      (pc_out),
      .pc_plus2    (pc_plus2),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready),
      .halted      (halted),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int n = 0;
      while (dbg_state !== s && n < budget) begin
         tick();
         n++;
      end
      check(name, {13'b0, dbg_state}, {13'b0, s});
   endtask

   task automatic wait_handoffs_left(input int left, input int budget, input string name);
      int n = 0;
      while (exp_pc_q.size() != left && n < budget) begin
         tick();
         n++;
      end
      check(name, 16'(exp_pc_q.size()), 16'(left));
   endtask

   task automatic push_handoff(input logic [15:0] pc, input logic [15:0] ir, input logic [15:0] p2);
      exp_pc_q.push_back(pc);
      exp_ir_q.push_back(ir);
      exp_p2_q.push_back(p2);
   endtask

   // instruction memory: answers each request mem_delay cycles later
   initial begin
      imem_valid = 1'b0;
      imem_rdata = '0;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         imem_valid = 1'b0;
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = mem_q[0].data;
            void'(mem_q.pop_front());
         end
         if (imem_req) mem_q.push_back('{cyc + mem_delay, imem_addr ^ mem_xor});
      end
   end

   // monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (imem_req) begin
               if (exp_addr_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_req: got request at %h, expected none", imem_addr);
               end else begin
                  check("imem_addr", imem_addr, exp_addr_q.pop_front());
               end
            end
            if (ir_valid && ir_ready && !stall) begin
               if (exp_pc_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_handoff: got pc %h ir %h, expected none", pc_out, ir_out);
               end else begin
                  check("handoff_pc", pc_out, exp_pc_q.pop_front());
                  check("handoff_ir", ir_out, exp_ir_q.pop_front());
                  check("handoff_pc_plus2", pc_plus2, exp_p2_q.pop_front());
               end
            end
         end
      end
   end

   // driver
   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      halt        = 1'b0;
      ir_ready    = 1'b1;
      mem_delay   = 1;
      mem_xor     = 16'hA5A5;
      repeat (2) tick();

      check("rst_imem_req", {15'b0, imem_req}, 16'h0000);
      check("rst_imem_addr", imem_addr, 16'h0000);
      check("rst_ir_out", ir_out, 16'h0000);
      check("rst_pc_out", pc_out, 16'h0000);
      check("rst_pc_plus2", pc_plus2, 16'h0002);
      check("rst_ir_valid", {15'b0, ir_valid}, 16'h0000);
      check("rst_halted", {15'b0, halted}, 16'h0000);

      // free-run, zero-wait memory
      foreach (exp_addr_q[i]) exp_addr_q.delete(i);
      exp_addr_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
      push_handoff(16'h0000, 16'hA5A5, 16'h0002);
      push_handoff(16'h0002, 16'hA5A7, 16'h0004);
      push_handoff(16'h0004, 16'hA5A1, 16'h0006);
      push_handoff(16'h0006, 16'hA5A3, 16'h0008);
      rst_n = 1'b1;
      wait_handoffs_left(0, 40, "t1_handoffs_done");
      stall = 1'b1;

      // stall holds the instruction at 0008
      push_handoff(16'h0008, 16'hA5AD, 16'h000A);
      mem_delay = 3;
      wait_state(ST_HOLD, 10, "t2_reach_hold");
      for (int i = 0; i < 6; i++) begin
         check("t2_ir_valid", {15'b0, ir_valid}, 16'h0001);
         check("t2_ir_out", ir_out, 16'hA5AD);
         check("t2_pc_out", pc_out, 16'h0008);
         check("t2_no_req", {15'b0, imem_req}, 16'h0000);
         tick();
      end
      exp_addr_q.push_back(16'h000A);
      stall = 1'b0;

      // redirect while the 000A fetch is outstanding
      wait_state(ST_WAIT, 10, "t3_reach_wait");
      exp_addr_q.push_back(16'h0040);
      redirect    = 1'b1;
      redirect_pc = 16'h0041;
      ir_ready    = 1'b0;
      tick();
      redirect = 1'b0;
      wait_state(ST_HOLD, 20, "t3_reach_hold");
      check("t3_ir_valid", {15'b0, ir_valid}, 16'h0001);
      check("t3_pc_out", pc_out, 16'h0040);
      check("t3_ir_out", ir_out, 16'hA5E5);
      check("t3_pc_plus2", pc_plus2, 16'h0042);

      // redirect from HOLD without ready, then wrap-around at FFFE
      mem_delay = 1;
      exp_addr_q.push_back(16'hFFFE);
      exp_addr_q.push_back(16'h0000);
      push_handoff(16'hFFFE, 16'h5A5B, 16'h0000);
      push_handoff(16'h0000, 16'hA5A5, 16'h0002);
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      tick();
      redirect = 1'b0;
      check("t4_ir_valid_dropped", {15'b0, ir_valid}, 16'h0000);
      check("t4_req_addr", imem_addr, 16'hFFFE);
      ir_ready = 1'b1;
      wait_handoffs_left(1, 20, "t4_fffe_handoff");

      // halt after the 0000 instruction is handed off
      halt = 1'b1;
      wait_state(ST_HALTED, 20, "t5_reach_halted");
      check("t5_halted", {15'b0, halted}, 16'h0001);
      check("t5_ir_valid", {15'b0, ir_valid}, 16'h0000);
      check("t5_pc_out", pc_out, 16'h0000);
      redirect    = 1'b1;
      redirect_pc = 16'h1234;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("t5_no_req", {15'b0, imem_req}, 16'h0000);
         tick();
      end
      check("t5_still_halted", {15'b0, halted}, 16'h0001);
      check("t5_addr_q_empty", 16'(exp_addr_q.size()), 16'h0000);

      // async reset from HALTED, then again mid-WAIT with a late response
      rst_n = 1'b0;
      #1;
      check("t6_halted_cleared", {15'b0, halted}, 16'h0000);
      tick();
      mem_delay = 3;
      exp_addr_q.push_back(16'h0000);
      rst_n = 1'b1;
      wait_state(ST_WAIT, 10, "t6_reach_wait");
      #2;
      rst_n   = 1'b0;
      mem_xor = 16'h1111;
      #1;
      check("t6_rst_imem_req", {15'b0, imem_req}, 16'h0000);
      check("t6_rst_ir_out", ir_out, 16'h0000);
      check("t6_rst_pc_out", pc_out, 16'h0000);
      check("t6_rst_ir_valid", {15'b0, ir_valid}, 16'h0000);
      check("t6_rst_state", {13'b0, dbg_state}, {13'b0, ST_BOOT});
      exp_addr_q.push_back(16'h0000);
      push_handoff(16'h0000, 16'h1111, 16'h0002);
      @(negedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      wait_state(ST_HALTED, 40, "t6_reach_halted");
      tick();
      check("end_addr_q_empty", 16'(exp_addr_q.size()), 16'h0000);
      check("end_handoff_q_empty", 16'(exp_pc_q.size()), 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
